// File: rtl/biu_bus_sequencer.sv
// Bus interface unit sequencer: runs T1..T4 bus cycles with wait states,
// splits unaligned word transfers into two byte cycles and aborts on ready timeout.
module biu_bus_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_word,
  input  logic [19:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [19:0] addr,
  output logic        rd,
  output logic        wr,
  output logic        bhe,
  output logic        a0,
  output logic [15:0] data_out,
  output logic        data_oe,
  input  logic [15:0] data_in,
  input  logic        ready,
  output logic        ale
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic        we_r, split_r, pend_r;
  logic [15:0] wdata_r;
  logic [7:0]  lo_byte_r, wait_cnt_r;
  logic [19:0] addr_r;
  logic        bhe_r, a0_r;
  logic [15:0] data_out_r;
  logic        rd_r, wr_r, ale_r, data_oe_r, rsp_valid_r, rsp_err_r;
  logic [15:0] rsp_rdata_r;

  logic        accept_s, timeout_s, done_s, final_s;
  logic [7:0]  lane_byte_s;
  logic [15:0] rdata_s;
  logic [19:0] nxt_addr_s;
  logic        nxt_bhe_s, nxt_a0_s;
  logic [15:0] nxt_dout_s;

  assign req_ready = (state_r == IDLE) && !rst;
  assign addr      = addr_r;
  assign bhe       = bhe_r;
  assign a0        = a0_r;
  assign data_out  = data_out_r;
  assign data_oe   = data_oe_r;
  assign rd        = rd_r;
  assign wr        = wr_r;
  assign ale       = ale_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

  // Next-state logic plus lane steering for the upcoming T1 and read capture
  always_comb begin
    state_s     = state_r;
    accept_s    = req_valid && req_ready;
    timeout_s   = (state_r == T3) && !ready && (wait_cnt_r == WAIT_LAST);
    done_s      = (state_r == T3) && ready;
    final_s     = timeout_s || (done_s && !pend_r);
    lane_byte_s = a0_r ? data_in[15:8] : data_in[7:0];

    // Split reads assemble {second byte, first byte}
    if (split_r) begin
      rdata_s = {lane_byte_s, lo_byte_r};
    end else if (bhe_r && !a0_r) begin
      rdata_s = data_in;
    end else begin
      rdata_s = {8'h00, lane_byte_s};
    end

    if (state_r == IDLE) begin
      nxt_addr_s = req_addr;
      nxt_bhe_s  = req_word | req_addr[0];
      nxt_a0_s   = req_addr[0];
      if (req_word && !req_addr[0]) begin
        nxt_dout_s = req_wdata;
      end else if (req_addr[0]) begin
        nxt_dout_s = {req_wdata[7:0], 8'h00};
      end else begin
        nxt_dout_s = {8'h00, req_wdata[7:0]};
      end
    end else begin
      nxt_addr_s = addr_r + 20'd1;
      nxt_bhe_s  = 1'b0;
      nxt_a0_s   = 1'b0;
      nxt_dout_s = {8'h00, wdata_r[15:8]};
    end

    case (state_r)
      IDLE:    state_s = accept_s ? T1 : IDLE;
      T1:      state_s = T2;
      T2:      state_s = T3;
      T3:      state_s = (ready || timeout_s) ? T4 : T3;
      T4:      state_s = pend_r ? T1 : IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture, bus outputs registered against the next state, and response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r        <= 1'b0;
      split_r     <= 1'b0;
      pend_r      <= 1'b0;
      wdata_r     <= 16'h0000;
      lo_byte_r   <= 8'h00;
      wait_cnt_r  <= 8'h00;
      addr_r      <= 20'h00000;
      bhe_r       <= 1'b0;
      a0_r        <= 1'b0;
      data_out_r  <= 16'h0000;
      rd_r        <= 1'b0;
      wr_r        <= 1'b0;
      ale_r       <= 1'b0;
      data_oe_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 16'h0000;
    end else begin
      if (accept_s) begin
        we_r    <= req_we;
        wdata_r <= req_wdata;
        split_r <= req_word & req_addr[0];
        pend_r  <= req_word & req_addr[0];
      end else if (timeout_s || (state_r == T4)) begin
        pend_r <= 1'b0;
      end

      if (state_s == T1) begin
        addr_r     <= nxt_addr_s;
        bhe_r      <= nxt_bhe_s;
        a0_r       <= nxt_a0_s;
        data_out_r <= nxt_dout_s;
      end

      if (state_r == T1) begin
        wait_cnt_r <= 8'h00;
      end else if ((state_r == T3) && !ready) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end

      if (done_s && pend_r) begin
        lo_byte_r <= lane_byte_s;
      end

      rd_r        <= !we_r && ((state_s == T2) || (state_s == T3));
      wr_r        <= we_r && ((state_s == T2) || (state_s == T3));
      data_oe_r   <= we_r && ((state_s == T2) || (state_s == T3) || (state_s == T4));
      ale_r       <= (state_s == T1);
      rsp_valid_r <= final_s;

      if (final_s) begin
        rsp_err_r   <= timeout_s;
        rsp_rdata_r <= (timeout_s || we_r) ? 16'h0000 : rdata_s;
      end
    end
  end

endmodule

// File: doc/biu_bus_sequencer.md
BIU_BUS_SEQUENCER -- requirements
Module: biu_bus_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum T3/Tw cycles waiting for ready before abort; legal range 1-255.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1: execution-unit request present.
REQ-005 SHALL have port req_ready, output, 1: request accepted on this cycle when req_valid is also high.
REQ-006 SHALL have port req_we, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port req_word, input, 1: 1 = 16-bit transfer, 0 = byte transfer.
REQ-008 SHALL have port req_addr, input, 20: physical byte address.
REQ-009 SHALL have port req_wdata, input, 16: write data; a byte write uses [7:0].
REQ-010 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata, output, 16: read data; byte reads are zero-extended.
REQ-012 SHALL have port rsp_err, output, 1: timeout abort; valid with rsp_valid.
REQ-013 SHALL have port addr, output, 20: bus address to memory_controller.
REQ-014 SHALL have ports rd and wr, output, 1 each: active-high bus strobes.
REQ-015 SHALL have ports bhe and a0, output, 1 each: bhe=1 enables D[15:8]; a0 is the address LSB.
REQ-016 SHALL have ports data_out, output, 16, and data_oe, output, 1: write-data driver and its enable; top level tri-states the shared data bus.
REQ-017 SHALL have port data_in, input, 16: read data from the bus.
REQ-018 SHALL have port ready, input, 1: transfer-complete signal from memory_controller.
REQ-019 SHALL have port ale, output, 1: address-latch strobe, high in T1 only.

Function
REQ-020 SHALL use state machine IDLE, T1, T2, T3, T4; Tw is T3 re-entered while ready=0.
- Transitions: IDLE->T1 on accept; T1->T2; T2->T3; T3->T4 when ready=1 or on timeout, else stay in T3.
- T4->T1 when a second split cycle is pending, else T4->IDLE.
REQ-021 SHALL drive req_ready=1 only in IDLE with rst low; the request is registered on accept, and req_* changes afterwards are ignored.
REQ-022 SHALL register addr, bhe and a0 on entry to T1 and hold them through T4; in IDLE they hold their last values.
REQ-023 SHALL assert rd (read) or wr (write) in T2 and T3 only; the strobes are never high at the same time.
REQ-024 SHALL, for writes, assert data_oe in T2, T3 and T4, and deassert it in IDLE and T1.
REQ-025 SHALL encode lanes per transfer type:
- Aligned word: bhe=1, a0=0, data_out=wdata.
- Even byte: bhe=0, a0=0, data on D[7:0].
- Odd byte: bhe=1, a0=1, data on D[15:8].
REQ-026 SHALL split a word request with req_addr[0]=1 into two bus cycles:
- Cycle 1: odd byte at addr, carrying wdata[7:0] on D[15:8].
- Cycle 2: even byte at (addr+1) mod 2^20, carrying wdata[15:8] on D[7:0]; 0xFFFFF wraps to 0x00000.
REQ-027 SHALL capture data_in on the T3 cycle in which ready=1, taking only the enabled lane(s) and assembling split reads as {cycle2 byte, cycle1 byte}.
REQ-028 SHALL pulse rsp_valid for exactly one cycle, in the T4 of the final bus cycle.
- Minimum latency, accept to rsp_valid: 4 cycles (single), 8 cycles (split).
- Each Tw cycle adds one cycle.
REQ-029 SHALL count wait cycles in T3 from 1; if the count reaches TIMEOUT_CYCLES with ready still 0:
- Go to T4 and set rsp_err=1 with rsp_rdata=0.
- Cancel any pending split second cycle.
- The counter clears on every T1.
REQ-030 SHALL ignore ready outside T3.
REQ-031 SHALL hold rsp_rdata and rsp_err until the next rsp_valid.

Reset
REQ-032 SHALL, while rst is high, force (asynchronously):
- state=IDLE;
- rd, wr, ale, data_oe, rsp_valid, rsp_err and req_ready to 0;
- addr, bhe, a0, data_out and rsp_rdata to 0;
- wait counter and split flag cleared.
REQ-033 SHALL abandon any in-flight transfer on rst without generating a response; the first accept after rst falls starts a fresh T1.

Verification
REQ-034 Aligned word read at 0x01234, ready tied 1, data_in=0xBEEF -> rd high 2 cycles, bhe=1, a0=0; rsp_valid 4 cycles after accept; rsp_rdata=0xBEEF; rsp_err=0.
REQ-035 Odd byte write at 0xB8001 with wdata=0x0041 -> bhe=1, a0=1, data_out[15:8]=0x41, wr high during T2-T3, data_oe high during T2-T4, single bus cycle.
REQ-036 Unaligned word read at 0xFFFFF; data_in=0x1200 on cycle 1 and 0x0034 on cycle 2 -> addr 0xFFFFF then 0x00000; rsp_rdata=0x3412; rsp_valid 8 cycles after accept.
REQ-037 Aligned read with ready=0 for 3 T3 cycles, then 1 -> exactly 3 Tw cycles, rsp_valid at cycle 7, rd held high throughout.
REQ-038 TIMEOUT_CYCLES=4, ready stuck 0 on an unaligned word write -> T4 after the 4th wait cycle; rsp_err=1; rsp_rdata=0; no second bus cycle.
REQ-039 rst asserted during Tw of a write -> rd, wr, data_oe drop immediately; no rsp_valid; after release, a new request completes normally.
